fpu_addsub_param: RTL

FPU_ADDSUB_PARAM -- requirements
Module: fpu_addsub_param

---
 rtl/fpu_addsub_param_if.sv | 28 ++
 rtl/fpu_addsub_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_param_if.sv
// Operand/result handshake bundle for fpu_addsub_param.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface fpu_addsub_param_if #(
    parameter int EXP_W = 10,
    parameter int MAN_W = 21
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] Op_A_in;
    logic [W-1:0] Op_B_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    modport master (
        output in_valid, op_sub, Op_A_in, Op_B_in, out_ready,
        input  in_ready, out_valid, data_out, status_out
    );

    modport slave (
        input  in_valid, op_sub, Op_A_in, Op_B_in, out_ready,
        output in_ready, out_valid, data_out, status_out
    );
endinterface

// File: rtl/fpu_addsub_param.sv
// Multi-cycle parameterised floating-point adder/subtractor, one operation in flight.
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub_param #(
    parameter int EXP_W = 10,
    parameter int MAN_W = 21
) (
    input  logic               clock_100Khz,
    input  logic               reset,
    fpu_addsub_param_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = MAN_W + 4;          // hidden, fraction, guard, round, sticky
    localparam int MW = XW + 1;             // plus carry-out
    localparam int EW = EXP_W + 2;          // signed working exponent

    localparam logic [EXP_W-1:0]     DIFF_MAX = EXP_W'(MAN_W + 2);
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ALIGN, S_OPERATE, S_NORMALIZE, S_ROUND, S_DONE
    } state_t;

    state_t                state_q, state_d;
    fp_t                   a_q, a_d, b_q, b_d;
    logic                  sub_q, sub_d;
    logic                  bsign_q, bsign_d, ssign_q, ssign_d;
    logic [EXP_W-1:0]      bexp_q, bexp_d, diff_q, diff_d;
    logic [XW-1:0]         bman_q, bman_d, sman_q, sman_d;
    logic                  sign_q, sign_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic [MW-1:0]         man_q, man_d;
    logic [W-1:0]          data_q, data_d;
    logic [3:0]            status_q, status_d;

    // Decode: B's sign absorbs the subtraction; exponent field 0 is treated as zero.
    logic          dec_sb, dec_b_big;
    logic [XW-1:0] dec_ma, dec_mb;
    assign dec_sb    = b_q.sign ^ sub_q;
    assign dec_ma    = (a_q.exp == '0) ? '0 : {1'b1, a_q.man, 3'b000};
    assign dec_mb    = (b_q.exp == '0) ? '0 : {1'b1, b_q.man, 3'b000};
    assign dec_b_big = b_q.exp > a_q.exp;

    // Align: bits pushed below the round position collapse into sticky.
    logic [XW-1:0] aln_shift, aln_res;
    logic          aln_lost;
    assign aln_shift = sman_q >> diff_q;
    assign aln_lost  = |(sman_q & ~({XW{1'b1}} << diff_q));
    assign aln_res   = (diff_q > DIFF_MAX) ? {{(XW-1){1'b0}}, |sman_q}
                                           : {aln_shift[XW-1:1], aln_shift[0] | aln_lost};

    logic          op_same, op_bge, op_sign;
    logic [MW-1:0] op_man;
    assign op_same = bsign_q == ssign_q;
    assign op_bge  = bman_q >= sman_q;
    assign op_man  = op_same ? ({1'b0, bman_q} + {1'b0, sman_q})
                   : op_bge  ? {1'b0, bman_q - sman_q}
                             : {1'b0, sman_q - bman_q};
    assign op_sign = (op_man == '0) ? 1'b0 : ((op_same || op_bge) ? bsign_q : ssign_q);

    logic [MAN_W:0]       rnd_man;
    logic                 rnd_g, rnd_r, rnd_s, rnd_inc, rnd_carry;
    logic [MAN_W+1:0]     rnd_sum;
    logic [MAN_W-1:0]     rnd_frac;
    logic signed [EW-1:0] rnd_exp;
    assign rnd_man = man_q[MW-2:3];
    assign rnd_g   = man_q[2];
    assign rnd_r   = man_q[1];
    assign rnd_s   = man_q[0];
`ifdef FPU_ROUND_NEAREST_EN
    assign rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_man[0]);
`else
    assign rnd_inc = 1'b0;
`endif
    assign rnd_sum   = {1'b0, rnd_man} + {{(MAN_W+1){1'b0}}, rnd_inc};
    assign rnd_carry = rnd_sum[MAN_W+1];
    assign rnd_frac  = rnd_carry ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
    assign rnd_exp   = exp_q + (rnd_carry ? EXP_ONE : EXP_ZERO);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        bsign_d  = bsign_q;
        ssign_d  = ssign_q;
        bexp_d   = bexp_q;
        diff_d   = diff_q;
        bman_d   = bman_q;
        sman_d   = sman_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        man_d    = man_q;
        data_d   = data_q;
        status_d = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.Op_A_in;
                    b_d     = bus.Op_B_in;
                    sub_d   = bus.op_sub;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_b_big) begin
                    bsign_d = dec_sb;     bexp_d = b_q.exp; bman_d = dec_mb;
                    ssign_d = a_q.sign;   sman_d = dec_ma;
                    diff_d  = b_q.exp - a_q.exp;
                end else begin
                    bsign_d = a_q.sign;   bexp_d = a_q.exp; bman_d = dec_ma;
                    ssign_d = dec_sb;     sman_d = dec_mb;
                    diff_d  = a_q.exp - b_q.exp;
                end
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                sman_d  = aln_res;
                exp_d   = $signed({2'b00, bexp_q});
                state_d = S_OPERATE;
            end
            S_OPERATE: begin
                man_d   = op_man;
                sign_d  = op_sign;
                state_d = S_NORMALIZE;
            end
            S_NORMALIZE: begin
                // Right shift keeps the lost bit in sticky; left shift only while unnormalised.
                if (man_q[MW-1]) begin
                    man_d = {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
                    exp_d = exp_q + EXP_ONE;
                end else if (!man_q[MW-2] && man_q != '0) begin
                    man_d = man_q << 1;
                    exp_d = exp_q - EXP_ONE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (man_q == '0) begin
                    data_d   = '0;
                    status_d = 4'd0;
                end else if (rnd_exp >= EXP_TOP) begin
                    data_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    status_d = 4'd1;
                end else if (rnd_exp <= EXP_ZERO) begin
                    data_d   = {sign_q, {(W-1){1'b0}}};
                    status_d = 4'd2;
                end else begin
                    data_d   = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                    status_d = (rnd_g | rnd_r | rnd_s) ? 4'd3 : 4'd0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            bsign_q  <= 1'b0;
            ssign_q  <= 1'b0;
            bexp_q   <= '0;
            diff_q   <= '0;
            bman_q   <= '0;
            sman_q   <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            man_q    <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            bsign_q  <= bsign_d;
            ssign_q  <= ssign_d;
            bexp_q   <= bexp_d;
            diff_q   <= diff_d;
            bman_q   <= bman_d;
            sman_q   <= sman_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;
endmodule
